mem_host_loader: RTL and testbench

- Host-side initiator for the shared byte-addressed program memory.
- Accepts a byte stream over a valid/ready interface and packs it little-endian into DATA_WIDTH words.
- Drives the memory's host write port (addr/data/mask/en) with one write per word, partial mask on the final word.
- Then reads the region back through the host read port (one-cycle read latency) and checks a byte checksum. Reports done/error to the debug/boot controller.

---
 rtl/mem_host_loader.sv | 196 +++++++++++++++++++
 tb/tb_mem_host_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_host_loader.sv
// Packs a byte stream little-endian into memory words, writes them through the host port,
// then reads the region back and compares byte checksums; done pulses once, error holds until the next start.
module mem_host_loader #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH-1:0]   length,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic [ADDR_WIDTH-1:0]   hw_addr,
  output logic [DATA_WIDTH-1:0]   hw_data,
  output logic [DATA_WIDTH/8-1:0] hw_mask,
  output logic                    hw_en,
  output logic [ADDR_WIDTH-1:0]   hr_addr,
  input  logic [DATA_WIDTH-1:0]   hr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int LANE_W     = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1;
  localparam int AW1        = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MW_A      = ADDR_WIDTH'(MASK_WIDTH);
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(MASK_WIDTH - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] FLUSH   = 3'd2;
  localparam logic [2:0] VERIFY  = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;
  localparam logic [2:0] DONE_ST = 3'd5;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] base_q, len_q, byte_cnt, wr_addr;
  logic [AW1-1:0]        words_q, rd_cnt;
  logic [MASK_WIDTH-1:0] last_mask_q;
  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] pack;
  logic [31:0]           wr_sum, rd_sum;
  logic                  rd_p1, rd_p1_last, rd_p2, rd_p2_last;

  logic [ADDR_WIDTH-1:0] aligned_base, len_rem;
  logic [AW1-1:0]        word_calc;
  logic [MASK_WIDTH-1:0] tail_mask, fill_mask;
  logic [DATA_WIDTH-1:0] pack_next;
  logic                  accept, last_byte, word_end;
  logic [31:0]           rd_word_sum, rd_sum_next;

  assign in_ready = (state == LOAD);
  assign accept   = in_ready && in_valid;

  always_comb begin
    aligned_base = base_addr - (base_addr % MW_A);
    len_rem      = length % MW_A;
    word_calc    = ({1'b0, length} + AW1'(MASK_WIDTH - 1)) / AW1'(MASK_WIDTH);
    tail_mask    = '0;
    for (int k = 0; k < MASK_WIDTH; k++) begin
      tail_mask[k] = (len_rem == '0) || (ADDR_WIDTH'(k) < len_rem);
    end
  end

  always_comb begin
    pack_next = pack | (DATA_WIDTH'(in_data) << {lane, 3'b000});
    fill_mask = '0;
    for (int k = 0; k < MASK_WIDTH; k++) begin
      fill_mask[k] = (LANE_W'(k) <= lane);
    end
    last_byte = (({1'b0, byte_cnt} + AW1'(1)) == {1'b0, len_q});
    word_end  = (lane == LAST_LANE) || last_byte;
  end

  // Only lanes that were actually written count toward the read-back sum.
  always_comb begin
    rd_word_sum = '0;
    for (int k = 0; k < MASK_WIDTH; k++) begin
      if (!rd_p2_last || last_mask_q[k]) begin
        rd_word_sum = rd_word_sum + {24'd0, hr_data[8*k +: 8]};
      end
    end
    rd_sum_next = rd_p2 ? (rd_sum + rd_word_sum) : rd_sum;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      words_q     <= '0;
      last_mask_q <= '0;
      byte_cnt    <= '0;
      lane        <= '0;
      pack        <= '0;
      wr_addr     <= '0;
      wr_sum      <= '0;
      rd_cnt      <= '0;
      rd_p1       <= 1'b0;
      rd_p1_last  <= 1'b0;
      rd_p2       <= 1'b0;
      rd_p2_last  <= 1'b0;
      rd_sum      <= '0;
      hw_addr     <= '0;
      hw_data     <= '0;
      hw_mask     <= '0;
      hw_en       <= 1'b0;
      hr_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      hw_en      <= 1'b0;
      done       <= 1'b0;
      rd_p2      <= rd_p1;
      rd_p2_last <= rd_p1_last;
      rd_sum     <= rd_sum_next;
      case (state)
        IDLE: begin
          if (start) begin
            base_q      <= aligned_base;
            len_q       <= length;
            words_q     <= word_calc;
            last_mask_q <= tail_mask;
            wr_addr     <= aligned_base;
            byte_cnt    <= '0;
            lane        <= '0;
            pack        <= '0;
            wr_sum      <= '0;
            rd_sum      <= '0;
            rd_cnt      <= '0;
            rd_p1       <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b1;
            state       <= (length == '0) ? DONE_ST : LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_sum   <= wr_sum + {24'd0, in_data};
            byte_cnt <= byte_cnt + ADDR_WIDTH'(1);
            if (word_end) begin
              hw_en   <= 1'b1;
              hw_addr <= wr_addr;
              hw_data <= pack_next;
              hw_mask <= fill_mask;
              pack    <= '0;
              lane    <= '0;
              wr_addr <= wr_addr + MW_A;
            end else begin
              pack <= pack_next;
              lane <= lane + LANE_W'(1);
            end
            // First read address goes out alongside the final write strobe.
            if (last_byte) begin
              state      <= FLUSH;
              hr_addr    <= base_q;
              rd_cnt     <= AW1'(1);
              rd_p1      <= 1'b1;
              rd_p1_last <= (words_q == AW1'(1));
            end
          end
        end
        FLUSH, VERIFY: begin
          if (rd_cnt != words_q) begin
            hr_addr    <= hr_addr + MW_A;
            rd_cnt     <= rd_cnt + AW1'(1);
            rd_p1      <= 1'b1;
            rd_p1_last <= ((rd_cnt + AW1'(1)) == words_q);
          end else begin
            rd_p1 <= 1'b0;
          end
          if (state == FLUSH) begin
            state <= VERIFY;
          end else if (rd_cnt == words_q) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          error <= (rd_sum_next != wr_sum);
          state <= DONE_ST;
        end
        DONE_ST: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_host_loader.sv
// Directed bench for mem_host_loader with a byte-array host memory model (write-first on collisions).
module tb_mem_host_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [20:0] base_addr;
  logic [20:0] length;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [20:0] hw_addr;
  logic [31:0] hw_data;
  logic [3:0]  hw_mask;
  logic        hw_en;
  logic [20:0] hr_addr;
  logic [31:0] hr_data;
  logic        busy;
  logic        done;
  logic        error;

  mem_host_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .hw_addr(hw_addr), .hw_data(hw_data), .hw_mask(hw_mask), .hw_en(hw_en),
    .hr_addr(hr_addr), .hr_data(hr_data), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];
  bit         corrupt;

  function automatic logic [7:0] wr_byte(input int i);
    logic [11:0] a;
    a = hw_addr[11:0] + 12'(i);
    return hw_data[8*i +: 8] ^ ((corrupt && a == 12'h105) ? 8'hFF : 8'h00);
  endfunction

  function automatic logic [7:0] mem_rd(input logic [11:0] a);
    logic [7:0] v;
    v = mem[a];
    for (int i = 0; i < 4; i++) begin
      if (hw_en && hw_mask[i] && (hw_addr[11:0] + 12'(i)) == a) v = wr_byte(i);
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h5A;
    end else if (hw_en) begin
      for (int i = 0; i < 4; i++) begin
        if (hw_mask[i]) mem[hw_addr[11:0] + 12'(i)] <= wr_byte(i);
      end
    end
    hr_data <= {mem_rd(hr_addr[11:0] + 12'd3), mem_rd(hr_addr[11:0] + 12'd2),
                mem_rd(hr_addr[11:0] + 12'd1), mem_rd(hr_addr[11:0])};
  end

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  tx [0:15];
  logic [20:0] wr_a [0:7];
  logic [31:0] wr_d [0:7];
  logic [3:0]  wr_m [0:7];
  int          wr_k [0:7];
  int          wr_n;
  logic [20:0] hr_log [0:7];
  int          hr_k [0:7];
  int          hr_n;
  int          done_k, done_cnt, busy_cnt, acc_n;
  logic        err_at1, err_at_done;

  // Called #1 after a rising edge; runs one transfer and logs everything observed.
  task automatic run(input logic [20:0] b, input logic [20:0] len, input int mode, input bit mid);
    int k, idx, post;
    bit seen;
    logic [20:0] hr_prev;
    wr_n = 0; hr_n = 0; done_k = 0; done_cnt = 0; busy_cnt = 0;
    idx = 0; post = 0; seen = 0; err_at1 = 1'b0; err_at_done = 1'b0;
    hr_prev = hr_addr;
    base_addr = b; length = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (post < 3 && k < 200) begin
      if (mid && k == 5) begin
        base_addr = 21'h300; length = 21'd4; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      in_valid = (mode == 0) ? 1'b1 : k[0];
      in_data  = (idx < 16) ? tx[idx] : 8'hFF;
      if (k == 1) err_at1 = error;
      #4;
      if (in_valid && in_ready) idx++;
      if (hw_en && wr_n < 8) begin
        wr_a[wr_n] = hw_addr; wr_d[wr_n] = hw_data; wr_m[wr_n] = hw_mask; wr_k[wr_n] = k;
        wr_n++;
      end
      if (done) begin
        done_cnt++;
        if (!seen) begin
          done_k = k;
          err_at_done = error;
        end
        seen = 1'b1;
      end
      if (busy) busy_cnt++;
      if (hr_addr != hr_prev && hr_n < 8) begin
        hr_log[hr_n] = hr_addr; hr_k[hr_n] = k; hr_n++;
        hr_prev = hr_addr;
      end
      if (seen) post++;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    acc_n = idx;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_two_words(input string tag);
    check({tag, "_wr_n"}, 32'(wr_n), 32'd2);
    check({tag, "_w0_addr"}, 32'(wr_a[0]), 32'h100);
    check({tag, "_w0_data"}, wr_d[0], 32'h04030201);
    check({tag, "_w0_mask"}, 32'(wr_m[0]), 32'hF);
    check({tag, "_w1_addr"}, 32'(wr_a[1]), 32'h104);
    check({tag, "_w1_data"}, wr_d[1], 32'h08070605);
    check({tag, "_w1_mask"}, 32'(wr_m[1]), 32'hF);
  endtask

  initial begin
    int s, hw_seen, idle_bad;
    n_tests = 0; n_fail = 0; corrupt = 1'b0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 16; i++) tx[i] = 8'(i + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 32'({in_ready, hw_en, busy, done, error}), 32'd0);
    check("rst_mask", 32'(hw_mask), 32'd0);
    check("rst_hw_addr", 32'(hw_addr), 32'd0);
    check("rst_hw_data", hw_data, 32'd0);
    check("rst_hr_addr", 32'(hr_addr), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Eight bytes, no stalls
    run(21'h100, 21'd8, 0, 1'b0);
    check_two_words("t1");
    check("t1_w0_cycle", 32'(wr_k[0]), 32'd5);
    check("t1_w1_cycle", 32'(wr_k[1]), 32'd9);
    check("t1_hr_n", 32'(hr_n), 32'd2);
    check("t1_hr0", 32'(hr_log[0]), 32'h100);
    check("t1_hr0_cycle", 32'(hr_k[0]), 32'd9);
    check("t1_hr1", 32'(hr_log[1]), 32'h104);
    check("t1_done_cycle", 32'(done_k), 32'd13);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd12);
    check("t1_error", 32'(err_at_done), 32'd0);
    check("t1_accepted", 32'(acc_n), 32'd8);
    s = 0;
    for (int i = 0; i < wr_n; i++)
      for (int j = 0; j < 4; j++)
        if (wr_m[i][j]) s += int'(wr_d[i][8*j +: 8]);
    check("t1_sum", 32'(s), 32'd36);

    // Unaligned base, partial last word
    tx[0] = 8'hAA; tx[1] = 8'hBB; tx[2] = 8'hCC; tx[3] = 8'hDD; tx[4] = 8'hEE;
    run(21'h203, 21'd5, 0, 1'b0);
    check("t2_wr_n", 32'(wr_n), 32'd2);
    check("t2_w0_addr", 32'(wr_a[0]), 32'h200);
    check("t2_w0_data", wr_d[0], 32'hDDCCBBAA);
    check("t2_w0_mask", 32'(wr_m[0]), 32'hF);
    check("t2_w1_addr", 32'(wr_a[1]), 32'h204);
    check("t2_w1_data", wr_d[1], 32'h000000EE);
    check("t2_w1_mask", 32'(wr_m[1]), 32'h1);
    check("t2_lane1_kept", 32'(mem[12'h205]), 32'h5A);
    check("t2_hr0", 32'(hr_log[0]), 32'h200);
    check("t2_done_cycle", 32'(done_k), 32'd10);
    check("t2_error", 32'(err_at_done), 32'd0);
    check("t2_accepted", 32'(acc_n), 32'd5);

    // Zero length
    run(21'h400, 21'd0, 0, 1'b0);
    check("t3_wr_n", 32'(wr_n), 32'd0);
    check("t3_hr_moves", 32'(hr_n), 32'd0);
    check("t3_done_cycle", 32'(done_k), 32'd2);
    check("t3_busy_cycles", 32'(busy_cnt), 32'd1);
    check("t3_accepted", 32'(acc_n), 32'd0);

    // Corrupted readback, then a clean run clears the error
    for (int i = 0; i < 16; i++) tx[i] = 8'(i + 1);
    corrupt = 1'b1;
    run(21'h100, 21'd8, 0, 1'b0);
    check("t4_error_at_done", 32'(err_at_done), 32'd1);
    check("t4_error_held", 32'(error), 32'd1);
    corrupt = 1'b0;
    run(21'h100, 21'd8, 0, 1'b0);
    check("t4b_error_cleared", 32'(err_at1), 32'd0);
    check("t4b_error", 32'(err_at_done), 32'd0);

    // Toggling valid and an ignored start mid-load
    run(21'h100, 21'd8, 1, 1'b1);
    check_two_words("t5");
    check("t5_w0_cycle", 32'(wr_k[0]), 32'd8);
    check("t5_w1_cycle", 32'(wr_k[1]), 32'd16);
    check("t5_done_cycle", 32'(done_k), 32'd20);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_error", 32'(err_at_done), 32'd0);

    // Reset after three bytes of a load
    base_addr = 21'h100; length = 21'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; hw_seen = 0;
    for (int i = 0; i < 3; i++) begin
      in_data = tx[i];
      #4;
      if (hw_en) hw_seen++;
      @(posedge clk); #1;
    end
    check("t6_busy_pre", 32'(busy), 32'd1);
    check("t6_in_ready_pre", 32'(in_ready), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_ctl", 32'({in_ready, hw_en, busy, done, error}), 32'd0);
    check("t6_rst_hw_addr", 32'(hw_addr), 32'd0);
    check("t6_rst_hw_data", hw_data, 32'd0);
    check("t6_rst_hr_addr", 32'(hr_addr), 32'd0);
    check("t6_no_write", 32'(hw_seen), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (in_ready || hw_en || busy) idle_bad++;
    end
    check("t6_idle_after", 32'(idle_bad), 32'd0);
    in_valid = 1'b0;
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
    run(21'h180, 21'd4, 0, 1'b0);
    check("t6_wr_n", 32'(wr_n), 32'd1);
    check("t6_w0_addr", 32'(wr_a[0]), 32'h180);
    check("t6_w0_data", wr_d[0], 32'h44332211);
    check("t6_w0_mask", 32'(wr_m[0]), 32'hF);
    check("t6_done_cycle", 32'(done_k), 32'd9);
    check("t6_error", 32'(err_at_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
